// File: rtl/fb_sprite_engine.sv
// CHIP-8 framebuffer engine: executes DXYN sprite XOR-draws and 00E0 clears
// against the 1-bpp 64x32 framebuffer through a request/grant memory port.
module fb_sprite_engine (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        clear,
    input  logic [7:0]  draw_x,
    input  logic [7:0]  draw_y,
    input  logic [3:0]  draw_n,
    input  logic [11:0] sprite_addr,
    output logic        busy,
    output logic        done,
    output logic        collision,
    output logic        mem_req,
    output logic        mem_we,
    output logic [11:0] mem_addr,
    output logic [7:0]  mem_wdata,
    input  logic        mem_grant,
    input  logic [7:0]  mem_rdata
);

    localparam logic [11:0] FB_BASE = 12'hF00;

    typedef enum logic [3:0] {
        IDLE, SPR_RD, SPR_WT, L_RD, L_WT, L_WR, R_RD, R_WT, R_WR, CLR_WR, DONE
    } state_t;

    state_t      state_q, state_d;
    logic [5:0]  x0_q, x0_d;
    logic [4:0]  y0_q, y0_d;
    logic [3:0]  n_q, n_d;
    logic [11:0] i_q, i_d;
    logic [3:0]  r_q, r_d;
    logic [7:0]  lmask_q, lmask_d;
    logic [7:0]  rmask_q, rmask_d;
    logic        acc_q, acc_d;
    logic [7:0]  clr_cnt_q, clr_cnt_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        collision_q, collision_d;
    logic        mem_req_q, mem_req_d;
    logic        mem_we_q, mem_we_d;
    logic [11:0] mem_addr_q, mem_addr_d;
    logic [7:0]  mem_wdata_q, mem_wdata_d;

    logic        granted;
    logic [15:0] shifted;
    logic [7:0]  lmask_new, rmask_new;
    logic [5:0]  row_cur, row_nxt;
    logic [4:0]  r_nxt;
    logic        next_ok;
    logic [11:0] fb_left, fb_right;
    logic        finish_row;
    logic        unused_bits;

    assign granted   = mem_req_q && mem_grant;
    // Upper byte is the left-column mask, lower byte the spill into the next byte.
    assign shifted   = {mem_rdata, 8'h00} >> x0_q[2:0];
    assign lmask_new = shifted[15:8];
    assign rmask_new = (x0_q[5:3] != 3'd7) ? shifted[7:0] : 8'h00;
    assign row_cur   = {1'b0, y0_q} + {2'b00, r_q};
    assign r_nxt     = {1'b0, r_q} + 5'd1;
    assign row_nxt   = {1'b0, y0_q} + {1'b0, r_nxt};
    assign next_ok   = (r_nxt < {1'b0, n_q}) && (row_nxt < 6'd32);
    assign fb_left   = FB_BASE + {4'h0, row_cur[4:0], x0_q[5:3]};
    assign fb_right  = FB_BASE + {4'h0, row_cur[4:0], x0_q[5:3] + 3'd1};
    assign unused_bits = ^{draw_x[7:6], draw_y[7:5], row_cur[5]};

    always_comb begin
        state_d     = state_q;
        x0_d        = x0_q;
        y0_d        = y0_q;
        n_d         = n_q;
        i_d         = i_q;
        r_d         = r_q;
        lmask_d     = lmask_q;
        rmask_d     = rmask_q;
        acc_d       = acc_q;
        clr_cnt_d   = clr_cnt_q;
        collision_d = collision_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        finish_row  = 1'b0;

        case (state_q)
            IDLE: begin
                if (clear) begin
                    state_d     = CLR_WR;
                    clr_cnt_d   = 8'h00;
                    acc_d       = 1'b0;
                    collision_d = 1'b0;
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b1;
                    mem_addr_d  = FB_BASE;
                    mem_wdata_d = 8'h00;
                end else if (start) begin
                    state_d     = SPR_RD;
                    x0_d        = draw_x[5:0];
                    y0_d        = draw_y[4:0];
                    n_d         = draw_n;
                    i_d         = sprite_addr;
                    r_d         = 4'd0;
                    acc_d       = 1'b0;
                    collision_d = 1'b0;
                    // A zero-height draw passes through SPR_RD without requesting.
                    if (draw_n != 4'd0) begin
                        mem_req_d  = 1'b1;
                        mem_we_d   = 1'b0;
                        mem_addr_d = sprite_addr;
                    end
                end
            end
            SPR_RD: begin
                if (!mem_req_q) begin
                    state_d = DONE;
                end else if (granted) begin
                    mem_req_d = 1'b0;
                    state_d   = SPR_WT;
                end
            end
            SPR_WT: begin
                lmask_d = lmask_new;
                rmask_d = rmask_new;
                if (lmask_new != 8'h00) begin
                    state_d    = L_RD;
                    mem_req_d  = 1'b1;
                    mem_we_d   = 1'b0;
                    mem_addr_d = fb_left;
                end else if (rmask_new != 8'h00) begin
                    state_d    = R_RD;
                    mem_req_d  = 1'b1;
                    mem_we_d   = 1'b0;
                    mem_addr_d = fb_right;
                end else begin
                    finish_row = 1'b1;
                end
            end
            L_RD: begin
                if (granted) begin
                    mem_req_d = 1'b0;
                    state_d   = L_WT;
                end
            end
            L_WT: begin
                if ((mem_rdata & lmask_q) != 8'h00) acc_d = 1'b1;
                mem_req_d   = 1'b1;
                mem_we_d    = 1'b1;
                mem_wdata_d = mem_rdata ^ lmask_q;
                state_d     = L_WR;
            end
            L_WR: begin
                if (granted) begin
                    if (rmask_q != 8'h00) begin
                        state_d    = R_RD;
                        mem_we_d   = 1'b0;
                        mem_addr_d = fb_right;
                    end else begin
                        finish_row = 1'b1;
                    end
                end
            end
            R_RD: begin
                if (granted) begin
                    mem_req_d = 1'b0;
                    state_d   = R_WT;
                end
            end
            R_WT: begin
                if ((mem_rdata & rmask_q) != 8'h00) acc_d = 1'b1;
                mem_req_d   = 1'b1;
                mem_we_d    = 1'b1;
                mem_wdata_d = mem_rdata ^ rmask_q;
                state_d     = R_WR;
            end
            R_WR: begin
                if (granted) finish_row = 1'b1;
            end
            CLR_WR: begin
                if (granted) begin
                    if (clr_cnt_q == 8'hFF) begin
                        mem_req_d = 1'b0;
                        state_d   = DONE;
                    end else begin
                        clr_cnt_d  = clr_cnt_q + 8'd1;
                        mem_addr_d = FB_BASE + {4'h0, clr_cnt_q + 8'd1};
                    end
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Rows are clipped at the bottom edge rather than wrapped.
        if (finish_row) begin
            mem_we_d = 1'b0;
            if (next_ok) begin
                r_d        = r_nxt[3:0];
                state_d    = SPR_RD;
                mem_req_d  = 1'b1;
                mem_addr_d = i_q + {8'h00, r_nxt[3:0]};
            end else begin
                mem_req_d = 1'b0;
                state_d   = DONE;
            end
        end

        if (state_d == DONE) collision_d = acc_q;
        done_d = (state_d == DONE);
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            x0_q        <= 6'd0;
            y0_q        <= 5'd0;
            n_q         <= 4'd0;
            i_q         <= 12'd0;
            r_q         <= 4'd0;
            lmask_q     <= 8'h00;
            rmask_q     <= 8'h00;
            acc_q       <= 1'b0;
            clr_cnt_q   <= 8'h00;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            collision_q <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= 12'd0;
            mem_wdata_q <= 8'h00;
        end else begin
            state_q     <= state_d;
            x0_q        <= x0_d;
            y0_q        <= y0_d;
            n_q         <= n_d;
            i_q         <= i_d;
            r_q         <= r_d;
            lmask_q     <= lmask_d;
            rmask_q     <= rmask_d;
            acc_q       <= acc_d;
            clr_cnt_q   <= clr_cnt_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            collision_q <= collision_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign collision = collision_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_fb_sprite_engine.sv
// Bench for fb_sprite_engine: 4 KiB memory model with optional grant stalls,
// pixel-level reference model, directed vector table and randomized draws.
module tb_fb_sprite_engine;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        clear = 1'b0;
    logic [7:0]  draw_x = 8'd0;
    logic [7:0]  draw_y = 8'd0;
    logic [3:0]  draw_n = 4'd0;
    logic [11:0] sprite_addr = 12'd0;
    logic        busy, done, collision, mem_req, mem_we;
    logic [11:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_grant = 1'b0;
    logic [7:0]  mem_rdata = 8'h00;

    fb_sprite_engine dut (
        .clk(clk), .reset(reset), .start(start), .clear(clear),
        .draw_x(draw_x), .draw_y(draw_y), .draw_n(draw_n), .sprite_addr(sprite_addr),
        .busy(busy), .done(done), .collision(collision),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_grant(mem_grant), .mem_rdata(mem_rdata)
    );

    initial forever #5 clk = ~clk;

    logic [7:0]  mem [0:4095];
    bit          ref_pix [0:31][0:63];
    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          stall_cnt, req_cnt, rd_cnt;
    bit          stall_mode = 1'b0;
    bit          rd_pend = 1'b0;
    logic [7:0]  rd_data;
    bit          hold_pend = 1'b0;
    logic [11:0] hold_addr;
    logic        hold_we;
    logic [7:0]  hold_wdata;

    typedef struct {
        string       name;
        bit          clr;
        bit          both;
        bit          pre_clear;
        logic [7:0]  x, y;
        logic [3:0]  n;
        logic [11:0] a;
        int          lat;
        bit          coll;
        int          rd;
        logic [11:0] ca0, ca1;
        logic [7:0]  cv0, cv1;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // One memory-side cycle: present pending read data, pick grant, perform transfer.
    task automatic tick();
        @(negedge clk);
        cyc++;
        mem_rdata = rd_pend ? rd_data : 8'($urandom);
        rd_pend = 1'b0;
        if (reset) begin
            hold_pend = 1'b0;
            mem_grant = 1'b1;
            return;
        end
        if (hold_pend) begin
            chk("req_held", {11'd0, mem_req}, 32'd1);
            chk("addr_held", {20'd0, mem_addr}, {20'd0, hold_addr});
            chk("we_held", {31'd0, mem_we}, {31'd0, hold_we});
            chk("wdata_held", {24'd0, mem_wdata}, {24'd0, hold_wdata});
        end
        mem_grant = stall_mode ? ($urandom_range(0, 2) != 0) : 1'b1;
        if (mem_req) req_cnt++;
        if (mem_req && mem_grant) begin
            if (mem_we) mem[mem_addr] = mem_wdata;
            else begin
                rd_pend = 1'b1;
                rd_data = mem[mem_addr];
                rd_cnt++;
            end
        end
        if (mem_req && !mem_grant) stall_cnt++;
        hold_pend  = mem_req && !mem_grant;
        hold_addr  = mem_addr;
        hold_we    = mem_we;
        hold_wdata = mem_wdata;
    endtask

    // Pixel-level model: XOR each set sprite bit onto the screen, clipping at the edges.
    task automatic model_op(input bit clr, input logic [7:0] x, input logic [7:0] y,
                            input logic [3:0] n, input logic [11:0] a,
                            output int lat, output bit coll);
        int x0, y0, row, col, k;
        bit lt, rt;
        logic [7:0] s;
        coll = 1'b0;
        if (clr) begin
            for (int r = 0; r < 32; r++)
                for (int c = 0; c < 64; c++) ref_pix[r][c] = 1'b0;
            lat = 257;
            return;
        end
        if (n == 0) begin
            lat = 2;
            return;
        end
        x0 = x % 64;
        y0 = y % 32;
        lat = 1;
        for (int r = 0; r < n; r++) begin
            row = y0 + r;
            if (row > 31) break;
            s = mem[(a + r) % 4096];
            lt = 1'b0;
            rt = 1'b0;
            for (int j = 0; j < 8; j++) begin
                col = x0 + j;
                if (s[7-j] && col <= 63) begin
                    if (col / 8 == x0 / 8) lt = 1'b1;
                    else rt = 1'b1;
                    if (ref_pix[row][col]) coll = 1'b1;
                    ref_pix[row][col] = ~ref_pix[row][col];
                end
            end
            k = int'(lt) + int'(rt);
            lat += 2 + 3 * k;
        end
    endtask

    task automatic check_fb(input string nm);
        int bad = 0;
        int first = -1;
        logic [7:0] e;
        logic [7:0] first_exp = 8'h00;
        for (int k = 0; k < 256; k++) begin
            for (int j = 0; j < 8; j++) e[7-j] = ref_pix[k/8][(k%8)*8 + j];
            if (mem[12'hF00 + k] !== e) begin
                if (first < 0) begin
                    first = k;
                    first_exp = e;
                end
                bad++;
            end
        end
        chk(nm, (first < 0) ? 32'd0 : {24'd0, mem[12'hF00 + first]},
            (first < 0) ? 32'd0 : {24'd0, first_exp});
        if (bad != 0) $display("  fb differs in %0d bytes, first at offset %0d", bad, first);
    endtask

    task automatic run_op(input bit clr, input bit both, input logic [7:0] x,
                          input logic [7:0] y, input logic [3:0] n, input logic [11:0] a,
                          input int inj, output int lat, output bit coll);
        int  t0, mlat, dcnt;
        bit  mcoll;
        model_op(clr | both, x, y, n, a, mlat, mcoll);
        start = ~clr | both;
        clear = clr | both;
        draw_x = x;
        draw_y = y;
        draw_n = n;
        sprite_addr = a;
        t0 = cyc;
        stall_cnt = 0;
        req_cnt = 0;
        rd_cnt = 0;
        tick();
        start = 1'b0;
        clear = 1'b0;
        chk("busy_at_t1", {31'd0, busy}, 32'd1);
        chk("coll_cleared_t1", {31'd0, collision}, 32'd0);
        while (!done && (cyc - t0) < 3000) begin
            tick();
            start = 1'b0;
            clear = 1'b0;
            if (inj != 0 && (cyc - t0) == inj) begin
                start = 1'b1;
                clear = 1'b1;
                draw_x = x + 8'd13;
            end
        end
        if (!done) begin
            chk("done_timeout", 32'd0, 32'd1);
            lat = -1;
            coll = 1'b0;
        end else begin
            lat = cyc - t0;
            coll = collision;
        end
        $display("op clr=%0d both=%0d x=%0d y=%0d n=%0d I=%03h stalls=%0d lat=%0d coll=%0d",
                 clr, both, x, y, n, a, stall_cnt, lat, coll);
        chk("lat_model", lat, mlat + stall_cnt);
        chk("coll_model", {31'd0, coll}, {31'd0, mcoll});
        tick();
        chk("done_one_cycle", {31'd0, done}, 32'd0);
        chk("idle_after_done", {31'd0, busy}, 32'd0);
        chk("coll_held", {31'd0, collision}, {31'd0, coll});
        if (inj != 0) begin
            dcnt = 0;
            for (int i = 0; i < 30; i++) begin
                tick();
                if (done || busy) dcnt++;
            end
            chk("ignored_cmd_no_activity", dcnt, 0);
        end
        check_fb("fb_model");
    endtask

    function automatic vec_t mk(string nm, bit clr, bit both, bit pc, logic [7:0] x,
                                logic [7:0] y, logic [3:0] n, logic [11:0] a, int lat,
                                bit coll, int rd, logic [11:0] ca0, logic [7:0] cv0,
                                logic [11:0] ca1, logic [7:0] cv1);
        vec_t v;
        v.name = nm; v.clr = clr; v.both = both; v.pre_clear = pc;
        v.x = x; v.y = y; v.n = n; v.a = a; v.lat = lat; v.coll = coll; v.rd = rd;
        v.ca0 = ca0; v.cv0 = cv0; v.ca1 = ca1; v.cv1 = cv1;
        return v;
    endfunction

    initial begin
        int  lat;
        bit  coll;
        logic [7:0] rx, ry;
        logic [3:0] rn;
        logic [11:0] ra;

        for (int i = 0; i < 4096; i++) mem[i] = 8'($urandom);
        mem[12'h050] = 8'hF0; mem[12'h051] = 8'h90; mem[12'h052] = 8'h90;
        mem[12'h053] = 8'h90; mem[12'h054] = 8'hF0;
        mem[12'h100] = 8'hFF; mem[12'h101] = 8'hFF;

        vecs.push_back(mk("clear",      1, 0, 0, 8'd0,  8'd0,  4'd0, 12'h000, 257, 0, 0,  12'hF00, 8'h00, 12'hFFF, 8'h00));
        vecs.push_back(mk("font0",      0, 0, 0, 8'd0,  8'd0,  4'd5, 12'h050, 26,  0, 10, 12'hF00, 8'hF0, 12'hF20, 8'hF0));
        vecs.push_back(mk("redraw",     0, 0, 0, 8'd0,  8'd0,  4'd5, 12'h050, 26,  1, 10, 12'hF00, 8'h00, 12'hF08, 8'h00));
        vecs.push_back(mk("edge_clip",  0, 0, 1, 8'd60, 8'd31, 4'd2, 12'h100, 6,   0, 2,  12'hFFF, 8'h0F, 12'hFFE, 8'h00));
        vecs.push_back(mk("split_x3",   0, 0, 1, 8'd3,  8'd0,  4'd1, 12'h100, 9,   0, 3,  12'hF00, 8'h1F, 12'hF01, 8'hE0));
        vecs.push_back(mk("split_x67",  0, 0, 1, 8'd67, 8'd0,  4'd1, 12'h100, 9,   0, 3,  12'hF00, 8'h1F, 12'hF01, 8'hE0));
        vecs.push_back(mk("start_clr",  0, 1, 0, 8'd3,  8'd0,  4'd1, 12'h100, 257, 0, 0,  12'hF00, 8'h00, 12'hF01, 8'h00));
        vecs.push_back(mk("n_zero",     0, 0, 0, 8'd5,  8'd5,  4'd0, 12'h100, 2,   0, 0,  12'hF00, 8'h00, 12'hF2D, 8'h00));

        repeat (3) tick();
        reset = 1'b0;
        tick();
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_collision", {31'd0, collision}, 32'd0);
        chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
        chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
        chk("rst_mem_addr", {20'd0, mem_addr}, 32'd0);
        chk("rst_mem_wdata", {24'd0, mem_wdata}, 32'd0);

        foreach (vecs[i]) begin
            if (vecs[i].pre_clear) run_op(1, 0, 8'd0, 8'd0, 4'd0, 12'h000, 0, lat, coll);
            run_op(vecs[i].clr, vecs[i].both, vecs[i].x, vecs[i].y, vecs[i].n, vecs[i].a, 0, lat, coll);
            chk({vecs[i].name, "_lat"}, lat, vecs[i].lat);
            chk({vecs[i].name, "_coll"}, {31'd0, coll}, {31'd0, vecs[i].coll});
            chk({vecs[i].name, "_reads"}, rd_cnt, vecs[i].rd);
            chk({vecs[i].name, "_byte0"}, {24'd0, mem[vecs[i].ca0]}, {24'd0, vecs[i].cv0});
            chk({vecs[i].name, "_byte1"}, {24'd0, mem[vecs[i].ca1]}, {24'd0, vecs[i].cv1});
        end

        // Zero-height draw must never touch the memory port.
        run_op(0, 0, 8'd9, 8'd9, 4'd0, 12'h100, 0, lat, coll);
        chk("n0_no_req", req_cnt, 0);

        // Commands arriving while busy are dropped.
        run_op(0, 0, 8'd21, 8'd4, 4'd4, 12'h050, 3, lat, coll);

        // Fifteen-row draw under random grant stalls.
        stall_mode = 1'b1;
        run_op(1, 0, 8'd0, 8'd0, 4'd0, 12'h000, 0, lat, coll);
        run_op(0, 0, 8'd29, 8'd3, 4'd15, 12'h300, 0, lat, coll);
        stall_mode = 1'b0;

        // Asynchronous reset in the middle of a draw.
        start = 1'b1; clear = 1'b0;
        draw_x = 8'd11; draw_y = 8'd2; draw_n = 4'd15; sprite_addr = 12'h400;
        tick();
        start = 1'b0;
        repeat (8) tick();
        @(posedge clk);
        #3 reset = 1'b1;
        #1;
        chk("async_rst_req", {31'd0, mem_req}, 32'd0);
        chk("async_rst_busy", {31'd0, busy}, 32'd0);
        tick();
        tick();
        reset = 1'b0;
        tick();
        chk("post_rst_done", {31'd0, done}, 32'd0);
        run_op(1, 0, 8'd0, 8'd0, 4'd0, 12'h000, 0, lat, coll);
        run_op(0, 0, 8'd3, 8'd0, 4'd1, 12'h100, 0, lat, coll);
        chk("post_rst_draw_lat", lat, 9);

        for (int t = 0; t < 24; t++) begin
            rx = 8'($urandom);
            ry = 8'($urandom);
            rn = 4'($urandom_range(0, 15));
            ra = 12'h200 + 12'($urandom_range(0, 12'hC00));
            stall_mode = (t % 2) == 1;
            if (t % 8 == 7) run_op(1, 0, 8'd0, 8'd0, 4'd0, 12'h000, 0, lat, coll);
            else run_op(0, 0, rx, ry, rn, ra, 0, lat, coll);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fb_sprite_engine.md
# fb_sprite_engine

Framebuffer drawing engine for the CHIP-8 display path. It executes the DXYN sprite-draw and 00E0 clear operations against the 1-bpp 64×32 framebuffer in shared 4 KiB memory. The VGA scan-out stage reads that framebuffer. The engine sits upstream of scan-out on the memory's write side, and uses a request/grant handshake so an arbiter can interleave it with display reads.

## Interface
- FB_BASE, 12'hF00: byte address of framebuffer row 0 / column-byte 0.
- clk  in  1  system clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-high; one clock; reset is asynchronous and active-high.
- start  in  1  one-cycle pulse: begin DXYN draw using draw_x/draw_y/draw_n/sprite_addr.
- clear  in  1  one-cycle pulse: begin framebuffer clear.
- draw_x  in  8  VX value; column = draw_x mod 64.
- draw_y  in  8  VY value; row = draw_y mod 32.
- draw_n  in  4  sprite height in rows (0–15).
- sprite_addr  in  12  I register; sprite byte r at (sprite_addr + r) mod 4096.
- busy  out  1  high from the cycle after acceptance until done.
- done  out  1  one-cycle pulse at completion.
- collision  out  1  VF result; valid and held from done until next acceptance.
- mem_req  out  1  memory access request; held until granted.
- mem_we  out  1  1 = write, 0 = read; qualified by mem_req.
- mem_addr  out  12  access address.
- mem_wdata  out  8  write data.
- mem_grant  in  1  access completes in any cycle where mem_req && mem_grant.
- mem_rdata  in  8  read data, valid the cycle after a granted read.

## Operation
- Framebuffer layout: byte address FB_BASE + row*8 + col/8. Bit 7 is the leftmost pixel, so pixel col maps to bit 7 − col%8.
- Commands are accepted only in IDLE. If start and clear are asserted in the same cycle, clear wins. Pulses arriving while busy are ignored and not queued.
- On acceptance, latch x0 = draw_x[5:0], y0 = draw_y[4:0], n, and I. Clear the internal collision accumulator.
- States: IDLE, SPR_RD, SPR_WT, L_RD, L_WT, L_WR, R_RD, R_WT, R_WR, CLR_WR, DONE.
- Draw, row r (0..n−1):
  - Row y0+r > 31: clip (no wrap). The draw terminates and goes to DONE.
  - SPR_RD: request a read of I+r. Advance on grant.
  - SPR_WT: capture the sprite byte s.
  - Masks: b = x0%8, c = x0/8. Left mask = s >> b. Right mask = (s << (8−b))[7:0] when b≠0 and c<7, else 0; this clips at column 63 with no wrap.
  - Left pass (L_RD/L_WT/L_WR), address row*8+c: read fb byte f; collision |= |(f & mask); write f ^ mask.
  - Right pass (R_RD/R_WT/R_WR): same at column-byte c+1.
  - Any pass whose mask is 0 is skipped entirely, with no memory access.
  - After the last row, go to DONE.
- n = 0: go directly to DONE with collision 0 and no memory access.
- Clear: CLR_WR writes 8'h00 to FB_BASE+0 … FB_BASE+255 in order, one byte per grant, then goes to DONE. collision = 0.
- DONE: done=1 for one cycle, collision presented, then return to IDLE.
- Reset (any time, including mid-operation) returns to IDLE. Outputs reset to 0: busy, done, collision, mem_req, mem_we, mem_addr, mem_wdata. Partially written framebuffer contents are left as-is.

## Timing
- Acceptance cycle is T0; the first state is entered at T0+1.
- mem_req, mem_we, mem_addr and mem_wdata are registered. They are stable from the request until the grant cycle inclusive.
- mem_rdata is sampled exactly one cycle after the read's grant cycle, independent of mem_grant in that cycle.
- With mem_grant tied high, costs are:
  - 2 cycles per sprite read.
  - 3 cycles per framebuffer pass.
  - 1 cycle per clear byte.
  - 1 cycle for DONE.
- Resulting latency: done rises at T0 + 1 + Σrows(2 + 3·k_r), where k_r ∈ {0,1,2} is the number of non-skipped passes. Clear: done at T0 + 257.
- Each cycle of grant stall extends the latency by exactly one cycle. No request is dropped or duplicated.
- collision updates only in L_WT/R_WT. Its externally visible value changes only at acceptance (cleared) and at DONE.

## Test plan
- Clear then draw: clear; then draw font "0" (F0 90 90 90 F0) at x=0, y=0, n=5, grant high. Expect bytes FB_BASE+0/8/16/24/32 = F0,90,90,90,F0; collision 0; done at T0+1+5·5 = T0+26.
- Redraw for collision: draw the same sprite again at the same position. Expect those bytes to be 00 and collision = 1.
- Unaligned split: empty fb, sprite FF at x=60, y=31, n=2. Expect byte 7 of row 31 = 0F. Right pass skipped (c=7). Row 32 clipped, so the second sprite byte is never read. done at T0+6.
- Split across bytes: sprite FF at x=3. Expect fb bytes 1F and E0. x=67 produces the same result (mod 64).
- Handshake: random mem_grant stalls during a 15-row draw. Expect the final fb identical to the no-stall run, and address/data held stable while ungranted.
- Control edges:
  - n=0 gives done at T0+2 with no mem_req.
  - start during busy is ignored.
  - start and clear in the same cycle runs a clear.
  - reset mid-draw drops mem_req and busy in the same cycle (async), and the engine next accepts a new start normally.
